// File: rtl/alarm_chime_pkg.sv
// Shared definitions for the alarm chime controller: FSM state encoding,
// parameter defaults and counter widths.
package alarm_chime_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        QUALIFY   = 3'd1,
        BEEP_ON   = 3'd2,
        BEEP_OFF  = 3'd3,
        LAMP_ONLY = 3'd4
    } state_t;

    localparam int DEF_DEBOUNCE_CYC = 4;
    localparam int DEF_BEEP_ON_CYC  = 8;
    localparam int DEF_BEEP_OFF_CYC = 8;
    localparam int DEF_BEEP_NUM     = 6;

    localparam int TIMER_W = 8;
    localparam int CNT_W   = 4;

    // A phase of N cycles is timed by loading N-1 and leaving the state when
    // the counter reaches zero, so the state is occupied for exactly N edges.
    function automatic logic [TIMER_W-1:0] timer_load(input int cyc);
        return TIMER_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// 8-bit loadable down-counter. Loads on request, otherwise counts down and
// parks at zero (never wraps). done is high while the count is zero.
module cycle_timer
    import alarm_chime_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               done
);

    logic [TIMER_W-1:0] cnt;

    // Count register: synchronous clear, load has priority over decrement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/alarm_chime_ctrl.sv
// Alarm chime controller: debounces a level alarm request, sounds a fixed
// number of beeps with the warning lamp lit, then keeps only the lamp on
// until the request goes away.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no alarm; all outputs low, beep count cleared
//   QUALIFY   | alarm seen, waiting for DEBOUNCE_CYC consecutive high cycles
//   BEEP_ON   | buzzer and lamp high for BEEP_ON_CYC cycles
//   BEEP_OFF  | buzzer low, lamp high for BEEP_OFF_CYC cycles
//   LAMP_ONLY | all beeps done; lamp high until the alarm drops
module alarm_chime_ctrl
    import alarm_chime_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int BEEP_ON_CYC  = DEF_BEEP_ON_CYC,
    parameter int BEEP_OFF_CYC = DEF_BEEP_OFF_CYC,
    parameter int BEEP_NUM     = DEF_BEEP_NUM
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alarm,
    output logic       buzzer,
    output logic       lamp,
    output logic [3:0] beep_cnt,
    output logic [2:0] state
);

    localparam logic [TIMER_W-1:0] QUAL_LOAD = timer_load(DEBOUNCE_CYC);
    localparam logic [TIMER_W-1:0] ON_LOAD   = timer_load(BEEP_ON_CYC);
    localparam logic [TIMER_W-1:0] OFF_LOAD  = timer_load(BEEP_OFF_CYC);
    localparam logic [CNT_W-1:0]   NUM_BEEPS = CNT_W'(BEEP_NUM);

    logic               alarm_q;
    state_t             state_q;
    state_t             state_nxt;
    logic               buzzer_nxt;
    logic               lamp_nxt;
    logic [CNT_W-1:0]   beep_cnt_nxt;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_load_val;
    logic               tmr_done;

    // One shared timer covers qualify, on and off phases; it is reloaded on
    // every state change so each phase starts from a full count.
    cycle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .done     (tmr_done)
    );

    // Input register plus FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alarm_q  <= 1'b0;
            state_q  <= IDLE;
            buzzer   <= 1'b0;
            lamp     <= 1'b0;
            beep_cnt <= '0;
        end else begin
            alarm_q  <= alarm;
            state_q  <= state_nxt;
            buzzer   <= buzzer_nxt;
            lamp     <= lamp_nxt;
            beep_cnt <= beep_cnt_nxt;
        end
    end

    // Next state and next output values; a dropped alarm beats timer expiry.
    always_comb begin
        state_nxt    = state_q;
        buzzer_nxt   = buzzer;
        lamp_nxt     = lamp;
        beep_cnt_nxt = beep_cnt;

        case (state_q)
            IDLE: begin
                buzzer_nxt   = 1'b0;
                lamp_nxt     = 1'b0;
                beep_cnt_nxt = '0;
                if (alarm_q) begin
                    state_nxt = QUALIFY;
                end
            end

            QUALIFY: begin
                if (!alarm_q) begin
                    state_nxt = IDLE;
                end else if (tmr_done) begin
                    state_nxt  = BEEP_ON;
                    buzzer_nxt = 1'b1;
                    lamp_nxt   = 1'b1;
                end
            end

            BEEP_ON: begin
                if (!alarm_q) begin
                    state_nxt    = IDLE;
                    buzzer_nxt   = 1'b0;
                    lamp_nxt     = 1'b0;
                    beep_cnt_nxt = '0;
                end else if (tmr_done) begin
                    state_nxt  = BEEP_OFF;
                    buzzer_nxt = 1'b0;
                    if (beep_cnt < NUM_BEEPS) begin
                        beep_cnt_nxt = beep_cnt + 1'b1;
                    end
                end
            end

            BEEP_OFF: begin
                if (!alarm_q) begin
                    state_nxt    = IDLE;
                    buzzer_nxt   = 1'b0;
                    lamp_nxt     = 1'b0;
                    beep_cnt_nxt = '0;
                end else if (tmr_done) begin
                    if (beep_cnt >= NUM_BEEPS) begin
                        state_nxt  = LAMP_ONLY;
                        buzzer_nxt = 1'b0;
                    end else begin
                        state_nxt  = BEEP_ON;
                        buzzer_nxt = 1'b1;
                    end
                end
            end

            LAMP_ONLY: begin
                if (!alarm_q) begin
                    state_nxt    = IDLE;
                    buzzer_nxt   = 1'b0;
                    lamp_nxt     = 1'b0;
                    beep_cnt_nxt = '0;
                end else begin
                    buzzer_nxt   = 1'b0;
                    lamp_nxt     = 1'b1;
                    beep_cnt_nxt = NUM_BEEPS;
                end
            end

            default: begin
                state_nxt    = IDLE;
                buzzer_nxt   = 1'b0;
                lamp_nxt     = 1'b0;
                beep_cnt_nxt = '0;
            end
        endcase
    end

    // Timer reload on every state change, with the length of the new phase.
    always_comb begin
        tmr_load     = (state_nxt != state_q);
        tmr_load_val = '0;
        case (state_nxt)
            QUALIFY:  tmr_load_val = QUAL_LOAD;
            BEEP_ON:  tmr_load_val = ON_LOAD;
            BEEP_OFF: tmr_load_val = OFF_LOAD;
            default:  tmr_load_val = '0;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_alarm_chime_ctrl.sv
// Directed bench for alarm_chime_ctrl with default parameters
// (debounce 4, on 8, off 8, six beeps). Edge numbers in comments count the
// edge that first samples alarm=1 as edge 0.
module tb_alarm_chime_ctrl;

    logic       clk;
    logic       rst_n;
    logic       alarm;
    logic       buzzer;
    logic       lamp;
    logic [3:0] beep_cnt;
    logic [2:0] state;

    int n_cmp;
    int n_bad;

    alarm_chime_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .alarm    (alarm),
        .buzzer   (buzzer),
        .lamp     (lamp),
        .beep_cnt (beep_cnt),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int bz, input int lp, input int bc);
        chk({tag, ".state"},    8'(state),    8'(st));
        chk({tag, ".buzzer"},   8'(buzzer),   8'(bz));
        chk({tag, ".lamp"},     8'(lamp),     8'(lp));
        chk({tag, ".beep_cnt"}, 8'(beep_cnt), 8'(bc));
    endtask

    initial begin
        int exp_bz;
        int exp_bc;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        alarm = 1'b0;

        // Reset state
        step(); step(); step();
        chk_all("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        step(); step();
        chk_all("idle", 0, 0, 0, 0);

        // Full episode with alarm held high
        alarm = 1'b1;
        step();                                  // edge 0
        chk_all("e0", 0, 0, 0, 0);
        for (int e = 1; e <= 4; e++) begin
            step();
            chk_all("qualify", 1, 0, 0, 0);
        end
        for (int e = 5; e <= 100; e++) begin
            step();
            exp_bz = (((e - 5) % 16) < 8) ? 1 : 0;
            exp_bc = (e < 13) ? 0 : ((e - 13) / 16 + 1);
            chk_all($sformatf("beep_e%0d", e), exp_bz ? 2 : 3, exp_bz, 1, exp_bc);
        end
        step();                                  // edge 101
        chk_all("lamp_only_entry", 4, 0, 1, 6);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("lamp_only_hold", 4, 0, 1, 6);
        end

        // Drop in LAMP_ONLY, then a fresh episode
        alarm = 1'b0;
        step();
        chk_all("lamp_drop_k", 4, 0, 1, 6);
        step();
        chk_all("lamp_drop_k1", 0, 0, 0, 0);
        alarm = 1'b1;
        step();                                  // edge 0
        chk_all("re_e0", 0, 0, 0, 0);
        for (int e = 1; e <= 4; e++) begin
            step();
            chk_all("re_qualify", 1, 0, 0, 0);
        end
        step();                                  // edge 5
        chk_all("re_e5", 2, 1, 1, 0);
        for (int e = 6; e <= 12; e++) step();
        chk_all("re_e12", 2, 1, 1, 0);
        step();                                  // edge 13
        chk_all("re_e13", 3, 0, 1, 1);

        // Alarm drops during first BEEP_OFF (sampled 0 at edge 15)
        step();                                  // edge 14
        alarm = 1'b0;
        step();                                  // edge 15
        chk_all("off_drop_e15", 3, 0, 1, 1);
        step();                                  // edge 16
        chk_all("off_drop_e16", 0, 0, 0, 0);
        step(); step();
        chk_all("off_drop_idle", 0, 0, 0, 0);

        // Short pulse: high for edges 0..2 only
        alarm = 1'b1;
        step();                                  // edge 0
        chk_all("pulse_e0", 0, 0, 0, 0);
        step();                                  // edge 1
        chk_all("pulse_e1", 1, 0, 0, 0);
        step();                                  // edge 2
        chk_all("pulse_e2", 1, 0, 0, 0);
        alarm = 1'b0;
        step();                                  // edge 3
        chk_all("pulse_e3", 1, 0, 0, 0);
        step();                                  // edge 4
        chk_all("pulse_e4", 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk_all("pulse_after", 0, 0, 0, 0);
        end

        // Reset mid first beep (rst_n low at edge 9)
        alarm = 1'b1;
        step();                                  // edge 0
        for (int e = 1; e <= 8; e++) step();
        chk_all("rst_e8", 2, 1, 1, 0);
        rst_n = 1'b0;
        step();                                  // edge 9
        chk_all("rst_e9", 0, 0, 0, 0);
        rst_n = 1'b1;
        step();                                  // edge 10, first with rst_n=1
        chk_all("rst_e10", 0, 0, 0, 0);
        for (int e = 11; e <= 14; e++) begin
            step();
            chk_all("rst_requalify", 1, 0, 0, 0);
        end
        step();                                  // edge 15
        chk_all("rst_e15", 2, 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
